// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce, single-cycle key events and an inactivity timeout.
// Optional build macro KEYPAD_DIGITS_ONLY_EN restricts key_valid to the digits 0-9.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned TIMEOUT_CYCLES  = 250000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  input  logic       clear,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       ok_pulse,
  output logic       tempo_limite
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV) + 1;
  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned TIM_W = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_DONE = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [TIM_W-1:0] TIM_LAST = TIM_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;

  localparam logic [3:0] CODE_OK = 4'hF;

  logic [3:0]       row_m_q, row_s_q;
  logic [1:0]       state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       col_n_q, col_n_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DEB_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       row_lat_q, row_lat_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic             key_valid_q, key_valid_d;
  logic             ok_pulse_q, ok_pulse_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             tempo_q, tempo_d;
  logic [TIM_W-1:0] timer_q, timer_d, timer_inc;
  logic             armed_q, armed_d;

  logic             single_low;
  logic [1:0]       row_hit;
  logic [3:0]       hit_code;

  // Keypad legend: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D.
  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    logic [3:0] drv;
    case (c)
      2'd0:    drv = 4'b1110;
      2'd1:    drv = 4'b1101;
      2'd2:    drv = 4'b1011;
      default: drv = 4'b0111;
    endcase
    return drv;
  endfunction

  // Row inputs are asynchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_m_q <= 4'b1111;
      row_s_q <= 4'b1111;
    end else begin
      row_m_q <= row_n;
      row_s_q <= row_m_q;
    end
  end

  // Only a single low row is a valid press; anything else is idle or ghosting.
  always_comb begin
    single_low = 1'b0;
    row_hit    = 2'd0;
    case (row_s_q)
      4'b1110: begin single_low = 1'b1; row_hit = 2'd0; end
      4'b1101: begin single_low = 1'b1; row_hit = 2'd1; end
      4'b1011: begin single_low = 1'b1; row_hit = 2'd2; end
      4'b0111: begin single_low = 1'b1; row_hit = 2'd3; end
      default: begin single_low = 1'b0; row_hit = 2'd0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      col_q       <= 2'd0;
      col_n_q     <= 4'b1110;
      div_q       <= '0;
      cnt_q       <= '0;
      row_lat_q   <= 4'b1111;
      row_idx_q   <= 2'd0;
      key_valid_q <= 1'b0;
      ok_pulse_q  <= 1'b0;
      key_code_q  <= 4'h0;
      tempo_q     <= 1'b0;
      timer_q     <= '0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      col_n_q     <= col_n_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      row_lat_q   <= row_lat_d;
      row_idx_q   <= row_idx_d;
      key_valid_q <= key_valid_d;
      ok_pulse_q  <= ok_pulse_d;
      key_code_q  <= key_code_d;
      tempo_q     <= tempo_d;
      timer_q     <= timer_d;
      armed_q     <= armed_d;
    end
  end

  // Scan / debounce / release FSM; cnt_q counts press stability in DEBOUNCE and release in HELD.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    row_lat_d   = row_lat_q;
    row_idx_d   = row_idx_q;
    key_valid_d = 1'b0;
    ok_pulse_d  = 1'b0;
    key_code_d  = key_code_q;
    cnt_inc     = cnt_q + DEB_W'(1);
    hit_code    = key_lookup(row_idx_q, col_q);

    case (state_q)
      ST_SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (single_low) begin
            row_lat_d = row_s_q;
            row_idx_d = row_hit;
            cnt_d     = '0;
            state_d   = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (row_s_q != row_lat_q) begin
          state_d = ST_SCAN;
          col_d   = col_q + 2'd1;
          div_d   = '0;
          cnt_d   = '0;
        end else if (cnt_inc == DEB_DONE) begin
          cnt_d   = '0;
          state_d = ST_HELD;
`ifdef KEYPAD_DIGITS_ONLY_EN
          if (hit_code <= 4'h9) begin
            key_valid_d = 1'b1;
            key_code_d  = hit_code;
          end else if (hit_code == CODE_OK) begin
            ok_pulse_d = 1'b1;
          end
`else
          key_valid_d = 1'b1;
          key_code_d  = hit_code;
          ok_pulse_d  = (hit_code == CODE_OK);
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HELD: begin
        if (row_s_q != 4'b1111) begin
          cnt_d = '0;
        end else if (cnt_inc == DEB_DONE) begin
          cnt_d   = '0;
          state_d = ST_SCAN;
          col_d   = 2'd0;
          div_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_SCAN;
        col_d   = 2'd0;
        div_d   = '0;
        cnt_d   = '0;
      end
    endcase

    col_n_d = col_drive(col_d);
  end

  // Inactivity timer: a key event re-arms it even if clear arrives in the same cycle.
  always_comb begin
    timer_d   = timer_q;
    armed_d   = armed_q;
    tempo_d   = 1'b0;
    timer_inc = timer_q + TIM_W'(1);
    if (key_valid_q) begin
      timer_d = '0;
      armed_d = 1'b1;
    end else if (clear) begin
      timer_d = '0;
      armed_d = 1'b0;
    end else if (armed_q) begin
      if (timer_inc == TIM_LAST) begin
        tempo_d = 1'b1;
        armed_d = 1'b0;
        timer_d = '0;
      end else begin
        timer_d = timer_inc;
      end
    end
  end

  assign col_n        = col_n_q;
  assign key_valid    = key_valid_q;
  assign key_code     = key_code_q;
  assign ok_pulse     = ok_pulse_q;
  assign tempo_limite = tempo_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: stimulus queues expected events, a monitor pops and compares.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 8;
  localparam int unsigned TMO      = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       ok_pulse;
  logic       tempo_limite;

  logic [15:0] pressed;

  typedef struct packed {
    logic        kv;
    logic        ok;
    logic        tmo;
    logic [3:0]  code;
    logic [31:0] delta;
  } ev_t;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cycle   = 0;
  int  last_kv = 0;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .row_n       (row_n),
    .col_n       (col_n),
    .clear       (clear),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .ok_pulse    (ok_pulse),
    .tempo_limite(tempo_limite)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Physical keypad: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && (col_n[c] === 1'b0)) row_n[r] = 1'b0;
  end

  initial begin
    ev_t obs;
    ev_t e;
    bit  ok_match;
    forever begin
      @(negedge clk);
      if (key_valid === 1'b1 || ok_pulse === 1'b1 || tempo_limite === 1'b1) begin
        obs.kv    = key_valid;
        obs.ok    = ok_pulse;
        obs.tmo   = tempo_limite;
        obs.code  = key_code;
        obs.delta = 32'(cycle - last_kv);
        if (key_valid === 1'b1) last_kv = cycle;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event kv=%b ok=%b tmo=%b code=%h required=no event",
                   obs.kv, obs.ok, obs.tmo, obs.code);
        end else begin
          e = exp_q.pop_front();
          ok_match = (obs.kv == e.kv) && (obs.ok == e.ok) && (obs.tmo == e.tmo) &&
                     (!e.kv || obs.code == e.code) && (!e.tmo || obs.delta == e.delta);
          if (!ok_match) begin
            n_fail++;
            $display("FAIL event actual kv=%b ok=%b tmo=%b code=%h delta=%0d required kv=%b ok=%b tmo=%b code=%h delta=%0d",
                     obs.kv, obs.ok, obs.tmo, obs.code, obs.delta,
                     e.kv, e.ok, e.tmo, e.code, e.delta);
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_key(input logic [3:0] code);
    ev_t e;
    e.kv = 1'b1; e.ok = 1'b0; e.tmo = 1'b0; e.code = code; e.delta = 32'd0;
    exp_q.push_back(e);
  endtask

  task automatic push_ok();
    ev_t e;
`ifdef KEYPAD_DIGITS_ONLY_EN
    e.kv = 1'b0;
`else
    e.kv = 1'b1;
`endif
    e.ok = 1'b1; e.tmo = 1'b0; e.code = 4'hF; e.delta = 32'd0;
    exp_q.push_back(e);
  endtask

  task automatic push_tmo();
    ev_t e;
    e.kv = 1'b0; e.ok = 1'b0; e.tmo = 1'b1; e.code = 4'h0; e.delta = 32'(TMO);
    exp_q.push_back(e);
  endtask

  task automatic press(input int r, input int c);
    pressed[r*4+c] = 1'b1;
  endtask

  task automatic release_all();
    pressed = '0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
  endtask

  task automatic wait_kv(input string name);
    int k = 0;
    while (key_valid !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (key_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s key_valid wait expired actual=0 required=1", name);
    end
  endtask

  initial begin
    logic [3:0] rot [4];
    rot[0] = 4'b1101; rot[1] = 4'b1011; rot[2] = 4'b0111; rot[3] = 4'b1110;
    pressed = '0;
    clear   = 1'b0;
    rst     = 1'b1;

    cycles(3);
    chk("reset_col_n", 32'(col_n), 32'(4'b1110));
    chk("reset_key_valid", 32'(key_valid), 32'd0);
    chk("reset_ok_pulse", 32'(ok_pulse), 32'd0);
    chk("reset_tempo", 32'(tempo_limite), 32'd0);
    chk("reset_key_code", 32'(key_code), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycles(SCAN_DIV);
      chk($sformatf("col_rotate_%0d", i), 32'(col_n), 32'(rot[i]));
    end

    // Clean press of '5'.
    push_key(4'h5);
    press(1, 1);
    cycles(40);
    release_all();
    cycles(20);
    chk("key_code_held", 32'(key_code), 32'h5);
    pulse_clear();

    // '9' bouncing every 3 cycles, then stable.
    push_key(4'h9);
    for (int i = 0; i < 10; i++) begin
      pressed[2*4+2] = (i % 2 == 0);
      cycles(3);
    end
    press(2, 2);
    cycles(50);
    release_all();
    cycles(20);
    pulse_clear();

    // Ghost press '1'+'4' is ignored, then '#'.
    press(0, 0);
    press(1, 0);
    cycles(40);
    release_all();
    cycles(20);
    push_ok();
    press(3, 2);
    cycles(40);
    release_all();
    cycles(20);
    pulse_clear();

    // Timeout after '2'.
    push_key(4'h2);
    push_tmo();
    press(0, 1);
    cycles(40);
    release_all();
    cycles(150);

    // Clear at +50 cancels the timeout.
    push_key(4'h2);
    press(0, 1);
    wait_kv("clear_case");
    release_all();
    cycles(49);
    pulse_clear();
    cycles(120);

    // '7' before the timeout of '3' re-arms the timer.
    push_key(4'h3);
    push_key(4'h7);
    push_tmo();
    press(0, 2);
    wait_kv("rearm_first");
    release_all();
    cycles(50);
    press(2, 0);
    wait_kv("rearm_second");
    release_all();
    cycles(150);

    // Reset at +40 drops the armed timer and clears outputs.
    push_key(4'h8);
    press(2, 1);
    wait_kv("reset_case");
    release_all();
    cycles(40);
    rst = 1'b1;
    cycles(3);
    chk("midrst_col_n", 32'(col_n), 32'(4'b1110));
    chk("midrst_key_code", 32'(key_code), 32'd0);
    chk("midrst_key_valid", 32'(key_valid), 32'd0);
    rst = 1'b0;
    cycles(150);

    cycles(20);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
